// File: rtl/alu_arbiter.sv
// Arbitrates one shared, clocked ALU between two requesters and returns each
// tagged result over a valid/ready channel. Vectors that are not one-hot are rejected with an error.
module alu_arbiter #(
  parameter int ALU_LAT = 1,
  parameter int INSTR_W = 47
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [31:0]        req0_rs1,
  input  logic [31:0]        req0_rs2,
  input  logic [11:0]        req0_imm,
  input  logic [INSTR_W-1:0] req0_instr,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [31:0]        req1_rs1,
  input  logic [31:0]        req1_rs2,
  input  logic [11:0]        req1_imm,
  input  logic [INSTR_W-1:0] req1_instr,
  output logic [31:0]        alu_rs1,
  output logic [31:0]        alu_rs2,
  output logic [11:0]        alu_imm,
  output logic [INSTR_W-1:0] alu_instructions,
  input  logic [31:0]        alu_result,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [31:0]        resp_data,
  output logic               resp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic [31:0]        rs1_q, rs1_d;
  logic [31:0]        rs2_q, rs2_d;
  logic [11:0]        imm_q, imm_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               id_q, id_d;
  logic               err_q, err_d;
  logic [31:0]        data_q, data_d;

  logic               grant0;
  logic               grant1;
  logic [INSTR_W-1:0] sel_instr;
  logic               sel_onehot;

  // Round-robin: on a tie, the port that did not win last time goes first.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && !grant0;
    sel_instr  = grant1 ? req1_instr : req0_instr;
    sel_onehot = (sel_instr != '0) &&
                 ((sel_instr & (sel_instr - INSTR_W'(1))) == '0);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    imm_d        = imm_q;
    instr_d      = instr_q;
    id_d         = id_q;
    err_d        = err_q;
    data_d       = data_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst && (grant0 || grant1)) begin
          req0_ready   = grant0;
          req1_ready   = grant1;
          rs1_d        = grant1 ? req1_rs1 : req0_rs1;
          rs2_d        = grant1 ? req1_rs2 : req0_rs2;
          imm_d        = grant1 ? req1_imm : req0_imm;
          instr_d      = sel_instr;
          id_d         = grant1;
          last_grant_d = grant1;
          data_d       = '0;
          if (sel_onehot) begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        // The ALU result is registered, so it is captured one cycle after
        // the counter has covered the full latency window.
        if (cnt_q == CNT_LAST) begin
          data_d  = alu_result;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      instr_q      <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_q        <= imm_d;
      instr_q      <= instr_d;
      id_q         <= id_d;
      err_q        <= err_d;
      data_q       <= data_d;
    end
  end

  // The instruction vector is gated to zero outside EXEC so the ALU idles.
  assign alu_rs1          = rs1_q;
  assign alu_rs2          = rs2_q;
  assign alu_imm          = imm_q;
  assign alu_instructions = (state_q == EXEC) ? instr_q : '0;
  assign resp_valid       = (state_q == RESP);
  assign resp_id          = id_q;
  assign resp_data        = data_q;
  assign resp_err         = err_q;
  assign busy             = (state_q != IDLE);

endmodule
